// File: rtl/p2p_cfg_regs_if.sv
// AXI4-Lite bundle between the host and the P2P filter
// configuration register file.
interface p2p_cfg_regs_if #(
  parameter int ADDR_W = 12
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb,
    input  bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb,
    output bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/p2p_cfg_regs.sv
// P2P filter rule registers and saturating status
// counters behind an AXI4-Lite slave port.
module p2p_cfg_regs #(
  parameter int ADDR_W    = 12,
  parameter int NUM_RULES = 2
) (
  input  logic                  axil_aclk,
  input  logic                  axil_rst,
  p2p_cfg_regs_if.slave         s_axil,
  output logic [383:0]          filter_rules,
  input  logic                  rule0_hit,
  input  logic                  rule1_hit,
  input  logic                  pkt_seen,
  input  logic                  pkt_drop
);

  if (NUM_RULES != 2) begin : g_bad_rules
    $error("p2p_cfg_regs: NUM_RULES must be 2");
  end

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE, R_RESP
  } rstate_t;

  wstate_t           wstate;
  rstate_t           rstate;
  logic [ADDR_W-1:0] wa;
  logic [31:0]       wd;
  logic [3:0]        ws;
  logic              commit;
  logic [31:0]       rf [12];
  logic [31:0]       cnt_hit0;
  logic [31:0]       cnt_hit1;
  logic [31:0]       cnt_seen;
  logic [31:0]       cnt_drop;
  logic              aw_fire;
  logic              w_fire;
  logic              have_aw;
  logic              have_w;
  logic [ADDR_W-1:0] wa_next;
  logic [3:0]        woff;
  logic              wok;
  logic [3:0]        clr;
  logic [3:0]        roff;
  logic [31:0]       rsel;
  logic              unused_bits;

  function automatic logic in_range(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1:6] == '0;
  endfunction

  function automatic logic [31:0] cnt_next(
    input logic [31:0] c,
    input logic        p,
    input logic        cl
  );
    if (cl) return '0;
    if (p && c != '1) return c + 32'd1;
    return c;
  endfunction

  assign unused_bits = ^{wa[1:0], s_axil.araddr[1:0]};

  always_comb begin
    aw_fire = s_axil.awvalid && s_axil.awready;
    w_fire  = s_axil.wvalid && s_axil.wready;
    have_aw = (wstate == W_HAVE_AW) || aw_fire;
    have_w  = (wstate == W_HAVE_W) || w_fire;
    wa_next = aw_fire ? s_axil.awaddr : wa;
    woff    = wa[5:2];
    wok     = in_range(wa);
    for (int i = 0; i < 4; i++) begin
      clr[i] = commit && wok && (woff == 4'(12 + i));
    end
  end

  // commit is a one-cycle flag aligned with the first W_RESP cycle
  always_ff @(posedge axil_aclk) begin
    if (axil_rst) begin
      wstate         <= W_IDLE;
      s_axil.awready <= 1'b1;
      s_axil.wready  <= 1'b1;
      s_axil.bvalid  <= 1'b0;
      s_axil.bresp   <= OKAY;
      wa             <= '0;
      wd             <= '0;
      ws             <= '0;
      commit         <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (wstate != W_RESP) begin
        if (aw_fire) begin
          wa             <= s_axil.awaddr;
          s_axil.awready <= 1'b0;
        end
        if (w_fire) begin
          wd            <= s_axil.wdata;
          ws            <= s_axil.wstrb;
          s_axil.wready <= 1'b0;
        end
        if (have_aw && have_w) begin
          wstate        <= W_RESP;
          commit        <= 1'b1;
          s_axil.bvalid <= 1'b1;
          s_axil.bresp  <= in_range(wa_next) ? OKAY : SLVERR;
        end else if (have_aw) begin
          wstate <= W_HAVE_AW;
        end else if (have_w) begin
          wstate <= W_HAVE_W;
        end
      end else if (s_axil.bready) begin
        wstate         <= W_IDLE;
        s_axil.bvalid  <= 1'b0;
        s_axil.bresp   <= OKAY;
        s_axil.awready <= 1'b1;
        s_axil.wready  <= 1'b1;
      end
    end
  end

  always_ff @(posedge axil_aclk) begin
    if (axil_rst) begin
      for (int i = 0; i < 12; i++) rf[i] <= '0;
    end else if (commit && wok && woff < 4'd12) begin
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) rf[woff][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge axil_aclk) begin
    if (axil_rst) begin
      cnt_hit0 <= '0;
      cnt_hit1 <= '0;
      cnt_seen <= '0;
      cnt_drop <= '0;
    end else begin
      cnt_hit0 <= cnt_next(cnt_hit0, rule0_hit, clr[0]);
      cnt_hit1 <= cnt_next(cnt_hit1, rule1_hit, clr[1]);
      cnt_seen <= cnt_next(cnt_seen, pkt_seen, clr[2]);
      cnt_drop <= cnt_next(cnt_drop, pkt_drop, clr[3]);
    end
  end

  always_comb begin
    filter_rules = '0;
    for (int r = 0; r < 2; r++) begin
      filter_rules[192*r +: 192] = {
        rf[6*r], rf[6*r+1], rf[6*r+2],
        rf[6*r+3], rf[6*r+4], rf[6*r+5]
      };
    end
  end

  always_comb begin
    roff = s_axil.araddr[5:2];
    rsel = '0;
    unique case (1'b1)
      (roff < 4'd12):  rsel = rf[roff];
      (roff == 4'd12): rsel = cnt_hit0;
      (roff == 4'd13): rsel = cnt_hit1;
      (roff == 4'd14): rsel = cnt_seen;
      (roff == 4'd15): rsel = cnt_drop;
    endcase
  end

  always_ff @(posedge axil_aclk) begin
    if (axil_rst) begin
      rstate         <= R_IDLE;
      s_axil.arready <= 1'b1;
      s_axil.rvalid  <= 1'b0;
      s_axil.rdata   <= '0;
      s_axil.rresp   <= OKAY;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (s_axil.arvalid) begin
            rstate         <= R_RESP;
            s_axil.arready <= 1'b0;
            s_axil.rvalid  <= 1'b1;
            if (in_range(s_axil.araddr)) begin
              s_axil.rdata <= rsel;
              s_axil.rresp <= OKAY;
            end else begin
              s_axil.rdata <= '0;
              s_axil.rresp <= SLVERR;
            end
          end
        end
        R_RESP: begin
          if (s_axil.rready) begin
            rstate         <= R_IDLE;
            s_axil.arready <= 1'b1;
            s_axil.rvalid  <= 1'b0;
            s_axil.rdata   <= '0;
            s_axil.rresp   <= OKAY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p2p_cfg_regs.sv
// Directed bench for p2p_cfg_regs: rule writes,
// strobes, counters, errors, backpressure, reset.
module tb_p2p_cfg_regs;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rule0_hit = 1'b0;
  logic         rule1_hit = 1'b0;
  logic         pkt_seen = 1'b0;
  logic         pkt_drop = 1'b0;
  logic [383:0] filter_rules;
  int           vectors = 0;
  int           miscompares = 0;

  p2p_cfg_regs_if #(.ADDR_W(12)) axil();

  p2p_cfg_regs #(.ADDR_W(12), .NUM_RULES(2)) dut (
    .axil_aclk    (clk),
    .axil_rst     (rst),
    .s_axil       (axil),
    .filter_rules (filter_rules),
    .rule0_hit    (rule0_hit),
    .rule1_hit    (rule1_hit),
    .pkt_seen     (pkt_seen),
    .pkt_drop     (pkt_drop)
  );

  always #5 clk = ~clk;

  task automatic axi_write(
    input  logic [11:0] addr,
    input  logic [31:0] data,
    input  logic [3:0]  strb,
    input  bit          aw_first,
    input  bit          pulse0,
    output logic [1:0]  resp
  );
    bit awd = 0;
    bit wd = 0;
    bit awf, wf;
    resp = 2'bxx;
    axil.awvalid = 1'b1;
    axil.awaddr  = addr;
    axil.wdata   = data;
    axil.wstrb   = strb;
    axil.wvalid  = !aw_first;
    for (int n = 0; n < 20 && !(awd && wd); n++) begin
      awf = axil.awvalid && axil.awready;
      wf  = axil.wvalid && axil.wready;
      @(negedge clk);
      if (awf) begin awd = 1; axil.awvalid = 1'b0; end
      if (wf) begin wd = 1; axil.wvalid = 1'b0; end
      if (awd && !wd && !wf) axil.wvalid = 1'b1;
    end
    if (!(awd && wd)) begin
      vectors++; miscompares++;
      $display("FAIL write_accept addr=%h: beats not taken", addr);
      axil.awvalid = 1'b0;
      axil.wvalid  = 1'b0;
      return;
    end
    rule0_hit = pulse0;
    for (int n = 0; n < 20; n++) begin
      if (axil.bvalid) begin
        resp = axil.bresp;
        @(negedge clk);
        rule0_hit = 1'b0;
        return;
      end
      @(negedge clk);
      rule0_hit = 1'b0;
    end
    vectors++; miscompares++;
    $display("FAIL write_resp addr=%h: no bvalid", addr);
  endtask

  task automatic axi_read(
    input  logic [11:0] addr,
    output logic [31:0] data,
    output logic [1:0]  resp
  );
    bit ard = 0;
    bit arf;
    data = 'x;
    resp = 2'bxx;
    axil.arvalid = 1'b1;
    axil.araddr  = addr;
    for (int n = 0; n < 20 && !ard; n++) begin
      arf = axil.arvalid && axil.arready;
      @(negedge clk);
      if (arf) begin ard = 1; axil.arvalid = 1'b0; end
    end
    if (!ard) begin
      vectors++; miscompares++;
      $display("FAIL read_accept addr=%h: ar not taken", addr);
      axil.arvalid = 1'b0;
      return;
    end
    for (int n = 0; n < 20; n++) begin
      if (axil.rvalid) begin
        data = axil.rdata;
        resp = axil.rresp;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    vectors++; miscompares++;
    $display("FAIL read_resp addr=%h: no rvalid", addr);
  endtask

  task automatic pulse(input int n, input bit seen);
    for (int i = 0; i < n; i++) begin
      rule0_hit = 1'b1;
      pkt_seen  = seen && (i < 2);
      @(negedge clk);
      rule0_hit = 1'b0;
      pkt_seen  = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [4:0] hs;
    hs = {axil.awready, axil.wready, axil.arready,
          axil.bvalid, axil.rvalid};
    vectors++;
    if (hs !== 5'b11100) begin
      miscompares++;
      $display("FAIL reset_hs: got %b want 11100", hs);
    end
    vectors++;
    if ({axil.bresp, axil.rresp, axil.rdata} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_resp: got %h %h %h want 0",
               axil.bresp, axil.rresp, axil.rdata);
    end
    vectors++;
    if (filter_rules !== 384'h0) begin
      miscompares++;
      $display("FAIL reset_rules: got %h want 0", filter_rules);
    end
  endtask

  task automatic test_rule_write();
    logic [1:0]  br, rr;
    logic [31:0] rd;
    axi_write(12'h000, 32'hC0A8_0001, 4'hF, 1'b1, 1'b0, br);
    vectors++;
    if (br !== 2'b00) begin
      miscompares++;
      $display("FAIL ipv4_bresp: got %b want 00", br);
    end
    vectors++;
    if (filter_rules[191:160] !== 32'hC0A8_0001) begin
      miscompares++;
      $display("FAIL ipv4_rule: got %h want c0a80001",
               filter_rules[191:160]);
    end
    axi_read(12'h000, rd, rr);
    vectors++;
    if ({rr, rd} !== {2'b00, 32'hC0A8_0001}) begin
      miscompares++;
      $display("FAIL ipv4_read: got %b %h want 00 c0a80001", rr, rd);
    end
    axi_write(12'h004, 32'h2001_0DB8, 4'hF, 1'b0, 1'b0, br);
    vectors++;
    if (filter_rules[159:128] !== 32'h2001_0DB8) begin
      miscompares++;
      $display("FAIL ipv6_hi: got %h want 20010db8",
               filter_rules[159:128]);
    end
  endtask

  task automatic test_strobe();
    logic [1:0]  br, rr;
    logic [31:0] rd;
    axi_write(12'h02C, 32'hAABB_CCDD, 4'h5, 1'b0, 1'b0, br);
    axi_read(12'h02C, rd, rr);
    vectors++;
    if (rd !== 32'h00BB_00DD) begin
      miscompares++;
      $display("FAIL strb_read: got %h want 00bb00dd", rd);
    end
    vectors++;
    if (filter_rules[223:192] !== 32'h00BB_00DD) begin
      miscompares++;
      $display("FAIL strb_rule: got %h want 00bb00dd",
               filter_rules[223:192]);
    end
    vectors++;
    if (filter_rules[383:352] !== 32'h0) begin
      miscompares++;
      $display("FAIL rule1_ipv4: got %h want 0",
               filter_rules[383:352]);
    end
  endtask

  task automatic test_counters();
    logic [1:0]  br, rr;
    logic [31:0] rd;
    pulse(5, 1'b1);
    axi_read(12'h030, rd, rr);
    vectors++;
    if (rd !== 32'd5) begin
      miscompares++;
      $display("FAIL hit0_count: got %0d want 5", rd);
    end
    axi_read(12'h038, rd, rr);
    vectors++;
    if (rd !== 32'd2) begin
      miscompares++;
      $display("FAIL seen_count: got %0d want 2", rd);
    end
    axi_write(12'h030, 32'h1234_5678, 4'h0, 1'b0, 1'b1, br);
    vectors++;
    if (br !== 2'b00) begin
      miscompares++;
      $display("FAIL clr_bresp: got %b want 00", br);
    end
    axi_read(12'h030, rd, rr);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL clr_race: got %0d want 0", rd);
    end
    axi_read(12'h038, rd, rr);
    vectors++;
    if (rd !== 32'd2) begin
      miscompares++;
      $display("FAIL seen_kept: got %0d want 2", rd);
    end
  endtask

  task automatic test_saturate();
    logic [1:0]  br, rr;
    logic [31:0] rd;
    force dut.cnt_drop = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cnt_drop;
    @(negedge clk);
    axi_read(12'h03C, rd, rr);
    vectors++;
    if (rd !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("FAIL drop_preset: got %h want fffffffe", rd);
    end
    for (int i = 0; i < 3; i++) begin
      pkt_drop = 1'b1;
      @(negedge clk);
      pkt_drop = 1'b0;
    end
    axi_read(12'h03C, rd, rr);
    vectors++;
    if (rd !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL drop_sat: got %h want ffffffff", rd);
    end
    axi_write(12'h03C, 32'h0, 4'hF, 1'b0, 1'b0, br);
    axi_read(12'h03C, rd, rr);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL drop_clr: got %h want 0", rd);
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0]  rr;
    logic [31:0] rd;
    axil.awvalid = 1'b1;
    axil.awaddr  = 12'h008;
    axil.wvalid  = 1'b1;
    axil.wdata   = 32'hDEAD_BEEF;
    axil.wstrb   = 4'hF;
    @(negedge clk);
    axil.awvalid = 1'b0;
    axil.wvalid  = 1'b0;
    axil.arvalid = 1'b1;
    axil.araddr  = 12'h008;
    @(negedge clk);
    axil.arvalid = 1'b0;
    vectors++;
    if ({axil.rvalid, axil.rdata} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL rw_race: got %b %h want 1 0",
               axil.rvalid, axil.rdata);
    end
    @(negedge clk);
    axi_read(12'h008, rd, rr);
    vectors++;
    if (rd !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rw_after: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0]   br, rr;
    logic [31:0]  rd;
    logic [383:0] exp;
    exp = '0;
    exp[191:160] = 32'hC0A8_0001;
    exp[159:128] = 32'h2001_0DB8;
    exp[127:96]  = 32'hDEAD_BEEF;
    exp[223:192] = 32'h00BB_00DD;
    axi_write(12'h040, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, br);
    vectors++;
    if (br !== 2'b10) begin
      miscompares++;
      $display("FAIL oor_bresp: got %b want 10", br);
    end
    vectors++;
    if (filter_rules !== exp) begin
      miscompares++;
      $display("FAIL oor_rules: got %h want %h", filter_rules, exp);
    end
    axi_read(12'h038, rd, rr);
    vectors++;
    if (rd !== 32'd2) begin
      miscompares++;
      $display("FAIL oor_cnt: got %0d want 2", rd);
    end
    axi_read(12'h100, rd, rr);
    vectors++;
    if ({rr, rd} !== {2'b10, 32'h0}) begin
      miscompares++;
      $display("FAIL oor_read: got %b %h want 10 0", rr, rd);
    end
  endtask

  task automatic test_back_to_back();
    axil.bready  = 1'b0;
    axil.rready  = 1'b0;
    axil.awvalid = 1'b1;
    axil.awaddr  = 12'h004;
    axil.wvalid  = 1'b1;
    axil.wdata   = 32'h1111_1111;
    axil.wstrb   = 4'hF;
    axil.arvalid = 1'b1;
    axil.araddr  = 12'h000;
    @(negedge clk);
    axil.wvalid  = 1'b0;
    axil.arvalid = 1'b0;
    axil.awaddr  = 12'h008;
    for (int n = 0; n < 10; n++) begin
      vectors++;
      if ({axil.bvalid, axil.rvalid, axil.awready,
           axil.bresp, axil.rresp} !== 7'b1100000) begin
        miscompares++;
        $display("FAIL hold_ctl[%0d]: got %b %b %b %b %b", n,
                 axil.bvalid, axil.rvalid, axil.awready,
                 axil.bresp, axil.rresp);
      end
      vectors++;
      if (axil.rdata !== 32'hC0A8_0001) begin
        miscompares++;
        $display("FAIL hold_rdata[%0d]: got %h want c0a80001",
                 n, axil.rdata);
      end
      @(negedge clk);
    end
    axil.bready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({axil.bvalid, axil.awready} !== 2'b01) begin
      miscompares++;
      $display("FAIL b_done: got bvalid=%b awready=%b want 0 1",
               axil.bvalid, axil.awready);
    end
    @(negedge clk);
    axil.awvalid = 1'b0;
    vectors++;
    if ({axil.awready, axil.wready} !== 2'b01) begin
      miscompares++;
      $display("FAIL have_aw: got awready=%b wready=%b want 0 1",
               axil.awready, axil.wready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    axil.rready = 1'b1;
    test_reset();
  endtask

  initial begin
    axil.awvalid = 1'b0;
    axil.awaddr  = '0;
    axil.wvalid  = 1'b0;
    axil.wdata   = '0;
    axil.wstrb   = '0;
    axil.bready  = 1'b1;
    axil.arvalid = 1'b0;
    axil.araddr  = '0;
    axil.rready  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_rule_write();
    test_strobe();
    test_counters();
    test_saturate();
    test_same_cycle();
    test_out_of_range();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
